// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared FSM encodings, grant indices and line constants for the memory bus arbiter
package mem_bus_arbiter_pkg;
    typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE} w_state_t;
    localparam int GR_IC = 0;
    localparam int GR_DC = 1;
    localparam int GR_UC = 2;
    localparam int GW_DC = 0;
    localparam int GW_UC = 1;
    localparam int LINE_BEATS_DEF = 16;
    localparam int STARVE_DEF = 4;
    localparam int CNT_W = 5;
    localparam int LINE_OFF = 6;
    function automatic logic [7:0] burst_len(input logic line, input int beats);
        return line ? 8'(beats - 1) : 8'd0;
    endfunction
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester and axi_interface signals of the memory bus arbiter
// slave is the arbiter's view; master is the requesters/axi_interface side.
interface mem_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req;
    logic [ADDR_W-1:0] ic_rd_addr, dc_rd_addr, uc_rd_addr, dc_wr_addr, uc_wr_addr;
    logic [DATA_W-1:0] dc_wr_data, uc_wr_data;
    logic [2:0] rd_grant;
    logic [1:0] wr_grant;
    logic rd_beat, dc_wr_beat;
    logic [DATA_W-1:0] rd_data;
    logic ic_rd_done, dc_rd_done, uc_rd_done, dc_wr_done, uc_wr_done;
    logic axi_ar_en, axi_aw_en;
    logic [ADDR_W-1:0] bus_rd_addr, bus_wr_addr;
    logic [DATA_W-1:0] bus_wr_data, bus_rd_data;
    logic [7:0] ar_burst_len, aw_burst_len;
    logic bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish;
    modport slave (
        input ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req,
        input ic_rd_addr, dc_rd_addr, uc_rd_addr, dc_wr_addr, uc_wr_addr,
        input dc_wr_data, uc_wr_data,
        input bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish, bus_rd_data,
        output rd_grant, wr_grant, rd_beat, rd_data, dc_wr_beat,
        output ic_rd_done, dc_rd_done, uc_rd_done, dc_wr_done, uc_wr_done,
        output axi_ar_en, axi_aw_en, bus_rd_addr, bus_wr_addr, bus_wr_data,
        output ar_burst_len, aw_burst_len
    );
    modport master (
        output ic_rd_req, dc_rd_req, uc_rd_req, dc_wr_req, uc_wr_req,
        output ic_rd_addr, dc_rd_addr, uc_rd_addr, dc_wr_addr, uc_wr_addr,
        output dc_wr_data, uc_wr_data,
        output bus_rd_data_ready, bus_wr_data_ready, bus_wr_data_finish, bus_rd_data,
        input rd_grant, wr_grant, rd_beat, rd_data, dc_wr_beat,
        input ic_rd_done, dc_rd_done, uc_rd_done, dc_wr_done, uc_wr_done,
        input axi_ar_en, axi_aw_en, bus_rd_addr, bus_wr_addr, bus_wr_data,
        input ar_burst_len, aw_burst_len
    );
endinterface

// File: rtl/mem_bus_rr_pick.sv
// mem_bus_rr_pick: uc > dc > ic read picker that promotes the I-cache after repeated lost arbitrations
module mem_bus_rr_pick
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic       take,
    output logic [2:0] pick
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;
    logic starve;
    assign starve = starve_cnt >= SW'(STARVE_LIMIT);
    always_comb
        pick = (starve && req[GR_IC]) ? 3'b001 :
               req[GR_UC] ? 3'b100 :
               req[GR_DC] ? 3'b010 :
               req[GR_IC] ? 3'b001 : 3'b000;
    always_ff @(posedge clk) begin
        if (!reset)
            starve_cnt <= '0;
        else if (take && |pick)
            starve_cnt <= pick[GR_IC] ? '0 :
                          (req[GR_IC] && !starve) ? starve_cnt + SW'(1) : starve_cnt;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one AXI master between I-cache, D-cache and uncached requesters
// Read and write channels arbitrate independently so a writeback can overlap a refill.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int LINE_BEATS   = LINE_BEATS_DEF,
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input logic clk,
    input logic reset,
    mem_bus_arbiter_if.slave bus
);
    r_state_t r_state;
    w_state_t w_state;
    logic [CNT_W-1:0] rd_cnt, wr_cnt;
    logic [2:0] rd_req, rd_pick;
    logic [DATA_W-1:0] wr_data_sel;
    logic wr_hit, rd_take;
    // A refill of the line being written back must wait for the writeback to land.
    assign wr_hit = bus.wr_grant[GW_DC] &&
                    bus.dc_rd_addr[ADDR_W-1:LINE_OFF] == bus.bus_wr_addr[ADDR_W-1:LINE_OFF];
    assign rd_req = {bus.uc_rd_req && w_state == W_IDLE && !bus.uc_wr_req,
                     bus.dc_rd_req && !wr_hit,
                     bus.ic_rd_req};
    assign rd_take = r_state == R_IDLE;
    mem_bus_rr_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk  (clk),
        .reset(reset),
        .req  (rd_req),
        .take (rd_take),
        .pick (rd_pick)
    );
    assign bus.rd_beat = bus.bus_rd_data_ready && r_state == R_BUSY;
    assign bus.rd_data = bus.bus_rd_data;
    assign bus.dc_wr_beat = bus.bus_wr_data_ready && bus.wr_grant[GW_DC];
    assign wr_data_sel = bus.wr_grant[GW_UC] ? bus.uc_wr_data : bus.dc_wr_data;
    assign bus.bus_wr_data = wr_data_sel;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= R_IDLE;
            bus.rd_grant <= '0;
            bus.axi_ar_en <= 1'b0;
            bus.bus_rd_addr <= '0;
            bus.ar_burst_len <= '0;
            rd_cnt <= '0;
            {bus.uc_rd_done, bus.dc_rd_done, bus.ic_rd_done} <= '0;
        end else begin
            {bus.uc_rd_done, bus.dc_rd_done, bus.ic_rd_done} <= '0;
            case (r_state)
                R_IDLE: if (|rd_pick) begin
                    r_state <= R_BUSY;
                    bus.rd_grant <= rd_pick;
                    bus.axi_ar_en <= 1'b1;
                    bus.bus_rd_addr <= rd_pick[GR_UC] ? bus.uc_rd_addr :
                                       rd_pick[GR_DC] ? bus.dc_rd_addr : bus.ic_rd_addr;
                    bus.ar_burst_len <= burst_len(!rd_pick[GR_UC], LINE_BEATS);
                end
                R_BUSY: if (bus.bus_rd_data_ready) begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                    if (rd_cnt + CNT_W'(1) == (bus.rd_grant[GR_UC] ? CNT_W'(1) : CNT_W'(LINE_BEATS))) begin
                        r_state <= R_DONE;
                        {bus.uc_rd_done, bus.dc_rd_done, bus.ic_rd_done} <= bus.rd_grant;
                        bus.rd_grant <= '0;
                        bus.axi_ar_en <= 1'b0;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                    rd_cnt <= '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state <= W_IDLE;
            bus.wr_grant <= '0;
            bus.axi_aw_en <= 1'b0;
            bus.bus_wr_addr <= '0;
            bus.aw_burst_len <= '0;
            wr_cnt <= '0;
            {bus.uc_wr_done, bus.dc_wr_done} <= '0;
        end else begin
            {bus.uc_wr_done, bus.dc_wr_done} <= '0;
            case (w_state)
                W_IDLE: if (bus.uc_wr_req || bus.dc_wr_req) begin
                    w_state <= W_BUSY;
                    bus.wr_grant <= bus.uc_wr_req ? 2'b10 : 2'b01;
                    bus.axi_aw_en <= 1'b1;
                    bus.bus_wr_addr <= bus.uc_wr_req ? bus.uc_wr_addr : bus.dc_wr_addr;
                    bus.aw_burst_len <= burst_len(!bus.uc_wr_req, LINE_BEATS);
                end
                W_BUSY: begin
                    if (bus.bus_wr_data_ready)
                        wr_cnt <= wr_cnt + CNT_W'(1);
                    if (bus.bus_wr_data_finish) begin
                        w_state <= W_DONE;
                        {bus.uc_wr_done, bus.dc_wr_done} <= bus.wr_grant;
                        bus.wr_grant <= '0;
                        bus.axi_aw_en <= 1'b0;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    wr_cnt <= '0;
                end
            endcase
        end
    end
    // Requesters hold their request until done; a line writeback must carry exactly LINE_BEATS beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (r_state == R_BUSY)
                assert ((bus.rd_grant & ~{bus.uc_rd_req, bus.dc_rd_req, bus.ic_rd_req}) == 3'b000);
            if (w_state == W_BUSY)
                assert ((bus.wr_grant & ~{bus.uc_wr_req, bus.dc_wr_req}) == 2'b00);
            if (w_state == W_BUSY && bus.bus_wr_data_finish && bus.wr_grant[GW_DC])
                assert (wr_cnt + CNT_W'(bus.bus_wr_data_ready) == CNT_W'(LINE_BEATS));
        end
    end
endmodule
